// File: rtl/mips32_fetch_queue_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel,
// redirect/halt controls from the pipeline, and the {IR, NPC} handoff to ID.
// The master modport is the fetch queue, the slave modport is its environment.
interface mips32_fetch_queue_if #(
    parameter int ADDR_W = 10
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              halt;
    logic              id_valid;
    logic [31:0]       id_ir;
    logic [31:0]       id_npc;
    logic              id_ready;

    modport master (
        output imem_req, imem_addr, id_valid, id_ir, id_npc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, halt, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_ir, id_npc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, halt, id_ready
    );
endinterface

// File: rtl/mips32_fetch_queue.sv
// mips32 instruction-fetch front end: issues word fetches, buffers returned
// words with their NPC in an in-order queue, and flushes on taken branches.
// Issue credit covers buffered entries plus in-flight requests, so the queue
// can never overflow. After a redirect, responses still in flight are counted
// in drop_q and discarded as they arrive.
// Optional build macro FETCH_STATS_EN adds stat_fetched / stat_discarded
// saturating counters.
module mips32_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic clk1,
    input  logic reset,
    mips32_fetch_queue_if.master bus
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_discarded
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [31:0]      ir_mem  [DEPTH];
    logic [31:0]      npc_mem [DEPTH];

    logic [CNT_W:0]   in_use;
    logic             req, fire, rsp_ok, rsp_drop, push, pop;

    assign in_use = {1'b0, count_q} + {1'b0, outst_q};
    assign req    = !reset && !bus.halt && !bus.redirect && (in_use < (CNT_W+1)'(DEPTH));

    assign bus.imem_req  = req;
    assign bus.imem_addr = fetch_pc_q[ADDR_W-1:0];
    assign bus.id_valid  = (count_q != '0);
    assign bus.id_ir     = ir_mem[head_q];
    assign bus.id_npc    = npc_mem[head_q];

    // Handshake decode and next-state for PCs, credits and queue pointers.
    always_comb begin
        fire      = req && bus.imem_gnt;
        // rvalid with nothing outstanding is a leftover from before a reset.
        rsp_ok    = bus.imem_rvalid && (outst_q != '0);
        rsp_drop  = rsp_ok && ((drop_q != '0) || bus.redirect);
        push      = rsp_ok && (drop_q == '0) && !bus.redirect;
        pop       = (count_q != '0) && bus.id_ready && !bus.redirect;
        outst_d   = outst_q + CNT_W'(fire) - CNT_W'(rsp_ok);

        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        drop_d     = drop_q;
        head_d     = head_q;
        tail_d     = tail_q;

        if (bus.redirect) begin
            // Everything still in flight belongs to the wrong path.
            fetch_pc_d = bus.redirect_pc;
            resp_pc_d  = bus.redirect_pc;
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            drop_d     = outst_d;
        end else begin
            if (fire) begin
                fetch_pc_d = fetch_pc_q + 32'd1;
            end
            if (rsp_ok && (drop_q != '0)) begin
                drop_d = drop_q - CNT_W'(1);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd1;
                tail_d    = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk1) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Queue storage; entries are only meaningful while counted in count_q.
    always_ff @(posedge clk1) begin
        if (push) begin
            ir_mem[tail_q]  <= bus.imem_rdata;
            npc_mem[tail_q] <= resp_pc_q + 32'd1;
        end
    end

    // A push into a full queue means the issue credit accounting is broken.
    always_ff @(posedge clk1) begin
        if (!reset) begin
            assert (!(push && (count_q == CNT_W'(DEPTH))));
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0]    stat_fetched_q, stat_discarded_q;
    logic [32:0]    fetched_sum, discarded_sum;
    logic [CNT_W:0] discard_inc;

    // Flushed entries count as discarded along with stale responses.
    always_comb begin
        discard_inc = (CNT_W+1)'(rsp_drop);
        if (bus.redirect) begin
            discard_inc = discard_inc + {1'b0, count_q};
        end
        fetched_sum   = {1'b0, stat_fetched_q} + 33'(pop);
        discarded_sum = {1'b0, stat_discarded_q} + 33'(discard_inc);
    end

    // Saturating statistics counters.
    always_ff @(posedge clk1) begin
        if (reset) begin
            stat_fetched_q   <= '0;
            stat_discarded_q <= '0;
        end else begin
            stat_fetched_q   <= fetched_sum[32]   ? 32'hFFFF_FFFF : fetched_sum[31:0];
            stat_discarded_q <= discarded_sum[32] ? 32'hFFFF_FFFF : discarded_sum[31:0];
        end
    end

    assign stat_fetched   = stat_fetched_q;
    assign stat_discarded = stat_discarded_q;
`endif
endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Randomized bench for mips32_fetch_queue. The reference model tracks the
// fetch stream as queues: requests in flight tagged with a path epoch, and
// the words buffered toward ID. A redirect bumps the epoch so older
// responses are stale; a reset marks everything in flight as ignored.
module tb_mips32_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam int          ADDR_W   = 10;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk1 = 1'b0;
    logic reset;
    always #5 clk1 = ~clk1;

    mips32_fetch_queue_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched, stat_discarded;
`endif

    mips32_fetch_queue #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC)
    ) dut (
        .clk1(clk1),
        .reset(reset),
        .bus(bus)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched(stat_fetched),
        .stat_discarded(stat_discarded)
`endif
    );

    typedef struct packed { logic [31:0] ir; logic [31:0] npc; } entry_t;
    typedef struct packed { logic [31:0] pc; logic [15:0] epoch; logic ign; } flight_t;
    typedef struct packed { logic [ADDR_W-1:0] addr; logic [31:0] due; } mreq_t;

    entry_t  mq[$];
    flight_t fl[$];
    mreq_t   mem_q[$];

    logic [31:0] m_fetch_pc;
    logic [15:0] m_epoch;
    logic [31:0] m_fetched, m_discarded;
    int unsigned cyc;
    int n_checks, n_pass;

    int lat_min, lat_max, p_gnt, p_ready, p_rvalid, p_redir, p_halt;
    bit halt_lvl;

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a, 6'h2b, ~a, a[5:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic step(input bit rst);
        bit      rv, exp_req, pushv, popv;
        int      live;
        entry_t  ne;
        flight_t f;
        logic [31:0] due;

        @(negedge clk1);
        reset = rst;
        if ($urandom_range(99) < p_halt) halt_lvl = !halt_lvl;
        bus.halt     = halt_lvl;
        bus.redirect = !rst && ($urandom_range(99) < p_redir);
        case ($urandom_range(3))
            0:       bus.redirect_pc = 32'h20;
            1:       bus.redirect_pc = 32'hFFFF_FFFE;
            default: bus.redirect_pc = $urandom;
        endcase
        bus.imem_gnt = ($urandom_range(99) < p_gnt);
        bus.id_ready = ($urandom_range(99) < p_ready);
        rv = (mem_q.size() != 0) && (mem_q[0].due <= cyc) && ($urandom_range(99) < p_rvalid);
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rv ? mem_word(mem_q[0].addr) : $urandom;
        #1;

        live = 0;
        foreach (fl[i]) if (!fl[i].ign) live++;
        exp_req = !rst && !bus.halt && !bus.redirect && (mq.size() + live < DEPTH);

        chk("imem_req", 32'(bus.imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", 32'(bus.imem_addr), 32'(m_fetch_pc[ADDR_W-1:0]));
        chk("id_valid", 32'(bus.id_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("id_ir", bus.id_ir, mq[0].ir);
            chk("id_npc", bus.id_npc, mq[0].npc);
        end
`ifdef FETCH_STATS_EN
        chk("stat_fetched", stat_fetched, m_fetched);
        chk("stat_discarded", stat_discarded, m_discarded);
`endif

        // Memory environment: in-order responses at least one cycle after grant.
        if (rv) void'(mem_q.pop_front());
        if (bus.imem_req && bus.imem_gnt) begin
            due = cyc + 32'($urandom_range(lat_max, lat_min));
            mem_q.push_back({bus.imem_addr, due});
        end

        // Reference model update for the coming clock edge.
        if (rst) begin
            if (rv && fl.size() != 0) void'(fl.pop_front());
            foreach (fl[i]) fl[i].ign = 1'b1;
            mq.delete();
            m_fetch_pc  = RESET_PC;
            m_epoch     = m_epoch + 16'd1;
            m_fetched   = '0;
            m_discarded = '0;
        end else begin
            pushv = 1'b0;
            ne    = '0;
            popv  = (mq.size() != 0) && bus.id_ready && !bus.redirect;
            if (rv && fl.size() != 0) begin
                f = fl.pop_front();
                if (!f.ign) begin
                    if (bus.redirect || f.epoch != m_epoch) begin
                        m_discarded = m_discarded + 32'd1;
                    end else begin
                        pushv = 1'b1;
                        ne    = {mem_word(f.pc[ADDR_W-1:0]), f.pc + 32'd1};
                    end
                end
            end
            if (bus.redirect) begin
                m_discarded = m_discarded + 32'(mq.size());
                mq.delete();
                m_epoch    = m_epoch + 16'd1;
                m_fetch_pc = bus.redirect_pc;
            end else begin
                if (popv) begin
                    void'(mq.pop_front());
                    m_fetched = m_fetched + 32'd1;
                end
                if (pushv) mq.push_back(ne);
                if (exp_req && bus.imem_gnt) begin
                    fl.push_back({m_fetch_pc, m_epoch, 1'b0});
                    m_fetch_pc = m_fetch_pc + 32'd1;
                end
            end
        end
        cyc++;
    endtask

    task automatic set_knobs(input int g, input int r, input int v, input int lmin,
                             input int lmax, input int rd, input int h);
        p_gnt = g; p_ready = r; p_rvalid = v; lat_min = lmin; lat_max = lmax;
        p_redir = rd; p_halt = h;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; cyc = 0;
        m_fetch_pc = RESET_PC; m_epoch = '0; m_fetched = '0; m_discarded = '0;
        halt_lvl = 1'b0;
        reset = 1'b1;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        bus.redirect = 1'b0; bus.redirect_pc = '0; bus.halt = 1'b0; bus.id_ready = 1'b0;
        set_knobs(0, 0, 100, 1, 1, 0, 0);

        for (int i = 0; i < 3; i++) step(1'b1);

        // Streaming: single-cycle memory, ID always ready.
        set_knobs(100, 100, 100, 1, 1, 0, 0);
        for (int i = 0; i < 40; i++) step(1'b0);

        // ID stalled with slow memory until the credit is exhausted, then drain.
        set_knobs(100, 0, 100, 3, 3, 0, 0);
        for (int i = 0; i < 20; i++) step(1'b0);
        set_knobs(100, 100, 100, 3, 3, 0, 0);
        for (int i = 0; i < 20; i++) step(1'b0);

        for (int round = 0; round < 4; round++) begin
            // Mixed random traffic with redirects and halt bursts.
            set_knobs(70, 60, 80, 1, 4, 8, 10);
            for (int i = 0; i < 1500; i++) step(1'b0);
            halt_lvl = 1'b0;

            // Reset with requests in flight; old responses must be ignored.
            set_knobs(100, 0, 100, 3, 3, 0, 0);
            for (int i = 0; i < 3; i++) step(1'b0);
            set_knobs(0, 100, 100, 3, 3, 0, 0);
            step(1'b1);
            for (int k = 0; k < 50 && mem_q.size() != 0; k++) step(1'b0);
            chk("drain_timeout", 32'(mem_q.size()), 32'd0);
            set_knobs(100, 100, 100, 1, 2, 0, 0);
            for (int i = 0; i < 20; i++) step(1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
